// File: rtl/fpu_issue_scheduler.sv
// fpu_issue_scheduler
// Issues add/mul/div/sqrt requests to fully pipelined FP units and books the
// shared result bus in a reservation table. slot_*_r[k] holds the operation
// whose result appears on wb_* k cycles from now. The wb_* registers are
// slot 0 of that table. A request is accepted only when its completion slot
// is free, so no two results ever share a cycle on the bus.
module fpu_issue_scheduler #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 2,
  parameter int LAT_SQRT = 6,
  parameter int MAX_LAT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  input  logic [3:0] req_tag,
  output logic       req_ready,
  output logic       issue_add,
  output logic       issue_mul,
  output logic       issue_div,
  output logic       issue_sqrt,
  output logic       wb_valid,
  output logic [1:0] wb_op,
  output logic [3:0] wb_tag,
  output logic [3:0] inflight
);

  localparam int IDX_W = $clog2(MAX_LAT);

  // The inflight port is 4 bits wide, so MAX_LAT is capped at 15.
  // Every unit latency must fit inside the table, with slot 0 being wb_*.
  if (MAX_LAT < 2 || MAX_LAT > 15 ||
      LAT_ADD  < 1 || LAT_ADD  > MAX_LAT - 1 ||
      LAT_MUL  < 1 || LAT_MUL  > MAX_LAT - 1 ||
      LAT_DIV  < 1 || LAT_DIV  > MAX_LAT - 1 ||
      LAT_SQRT < 1 || LAT_SQRT > MAX_LAT - 1) begin : g_bad_params
    $error("fpu_issue_scheduler: LAT_* must lie in 1..MAX_LAT-1 and MAX_LAT in 2..15");
  end

  // The function returns the latency of the unit selected by op.
  function automatic logic [IDX_W-1:0] lat_of(input logic [1:0] op);
    case (op)
      2'b00:   lat_of = IDX_W'(LAT_ADD);
      2'b01:   lat_of = IDX_W'(LAT_MUL);
      2'b10:   lat_of = IDX_W'(LAT_DIV);
      2'b11:   lat_of = IDX_W'(LAT_SQRT);
      default: lat_of = IDX_W'(LAT_ADD);
    endcase
  endfunction

  // These are the reservation-table slots 1..MAX_LAT-1.
  logic [MAX_LAT-1:1] slot_vld_r;
  logic [1:0]         slot_op_r  [MAX_LAT-1:1];
  logic [3:0]         slot_tag_r [MAX_LAT-1:1];

  logic [IDX_W-1:0]   lat_sel_s;
  logic               target_busy_s;
  logic               accept_s;

  // Handshake: the completion slot for the requested op must be free.
  // The slot must be free as seen before this cycle's shift.
  always_comb begin
    lat_sel_s     = lat_of(req_op);
    target_busy_s = slot_vld_r[lat_sel_s];
    req_ready     = 1'b0;
    if (!reset && !flush && !target_busy_s) begin
      req_ready = 1'b1;
    end else begin
      req_ready = 1'b0;
    end
    accept_s = req_valid & req_ready;
  end

  // The one-cycle start strobe goes only to the unit that was accepted.
  always_comb begin
    issue_add  = 1'b0;
    issue_mul  = 1'b0;
    issue_div  = 1'b0;
    issue_sqrt = 1'b0;
    if (accept_s) begin
      case (req_op)
        2'b00:   issue_add  = 1'b1;
        2'b01:   issue_mul  = 1'b1;
        2'b10:   issue_div  = 1'b1;
        2'b11:   issue_sqrt = 1'b1;
        default: issue_add  = 1'b0;
      endcase
    end else begin
      issue_add = 1'b0;
    end
  end

  for (genvar k = 1; k < MAX_LAT; k++) begin : g_slot
    logic       up_vld_s;
    logic [1:0] up_op_s;
    logic [3:0] up_tag_s;

    if (k == MAX_LAT - 1) begin : g_top
      assign up_vld_s = 1'b0;
      assign up_op_s  = 2'b00;
      assign up_tag_s = 4'h0;
    end else begin : g_mid
      assign up_vld_s = slot_vld_r[k+1];
      assign up_op_s  = slot_op_r[k+1];
      assign up_tag_s = slot_tag_r[k+1];
    end

    // Slot k either takes the entry shifting down from k+1 or captures a
    // newly accepted op. Its target slot LAT before the shift is LAT-1 after it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_vld_r[k] <= 1'b0;
        slot_op_r[k]  <= 2'b00;
        slot_tag_r[k] <= 4'h0;
      end else if (flush) begin
        slot_vld_r[k] <= 1'b0;
        slot_op_r[k]  <= 2'b00;
        slot_tag_r[k] <= 4'h0;
      end else if (accept_s && (int'(lat_sel_s) == k + 1)) begin
        slot_vld_r[k] <= 1'b1;
        slot_op_r[k]  <= req_op;
        slot_tag_r[k] <= req_tag;
      end else begin
        slot_vld_r[k] <= up_vld_s;
        slot_op_r[k]  <= up_op_s;
        slot_tag_r[k] <= up_tag_s;
      end
    end
  end

  // The result bus is slot 0. It is loaded from slot 1, or directly when LAT is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_op    <= 2'b00;
      wb_tag   <= 4'h0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_op    <= 2'b00;
      wb_tag   <= 4'h0;
    end else if (accept_s && (int'(lat_sel_s) == 1)) begin
      wb_valid <= 1'b1;
      wb_op    <= req_op;
      wb_tag   <= req_tag;
    end else begin
      wb_valid <= slot_vld_r[1];
      wb_op    <= slot_op_r[1];
      wb_tag   <= slot_tag_r[1];
    end
  end

  // The in-flight count includes the op that is currently on the result bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 4'd0;
    end else if (flush) begin
      inflight <= 4'd0;
    end else if (accept_s && !wb_valid && (int'(inflight) < MAX_LAT)) begin
      inflight <= inflight + 4'd1;
    end else if (!accept_s && wb_valid && (inflight != 4'd0)) begin
      inflight <= inflight - 4'd1;
    end else begin
      inflight <= inflight;
    end
  end

endmodule
